// File: rtl/lcd_msg_streamer.sv
// Multi-screen character ROM and streamer feeding the 16x2 LCD write controller.
// A start latches the screen number and the live field bytes, then every character of
// that screen is sent in order over a valid/ready port. Bytes with bit 7 set are slot
// markers: they are replaced by one hex digit of a latched field byte.
module lcd_msg_streamer #(
  parameter int unsigned NUM_MSGS   = 4,
  parameter int unsigned LINE_CHARS = 16,
  parameter int unsigned FIELDS     = 3,
  // Screen image, message-major: byte j of the ROM is MSG_IMAGE[8*j +: 8].
  parameter logic [NUM_MSGS*2*LINE_CHARS*8-1:0] MSG_IMAGE = {(NUM_MSGS*2*LINE_CHARS){8'h20}},
  localparam int unsigned SCR    = 2 * LINE_CHARS,
  localparam int unsigned MSEL_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
  localparam int unsigned IDX_W  = $clog2(SCR)
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [MSEL_W-1:0]     msgSel,
  input  logic [FIELDS*8-1:0]   fields,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  charValid,
  input  logic                  charReady,
  output logic [7:0]            charData,
  output logic [IDX_W-1:0]      charIdx
);

  localparam int unsigned ROM_DEPTH = NUM_MSGS * SCR;
  localparam int unsigned ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SCR - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MSEL_W-1:0]     msg_q, msg_d;
  logic [FIELDS*8-1:0]   fields_q, fields_d;
  logic                  error_q, error_d;
  logic [7:0]            char_data_q, char_data_d;

  logic [7:0]            rom [ROM_DEPTH];
  logic [ADDR_W-1:0]     rom_addr;
  logic [7:0]            rom_byte;
  logic [7:0]            sub_byte;
  logic [7:0]            field_byte;
  logic                  field_ok;
  logic [3:0]            nibble;
  logic                  msg_in_range;

  // Unpack the image into a byte-addressed constant table.
  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    assign rom[i] = MSG_IMAGE[8*i +: 8];
  end

  // ROM address from the latched screen and the current character position.
  always_comb begin
    rom_addr = ADDR_W'(32'(msg_q) * SCR + 32'(idx_q));
    rom_byte = rom[rom_addr];
  end

  // Slot substitution: bit 7 marks a slot, bits 6:1 pick the field, bit 0 picks the nibble.
  always_comb begin
    field_byte = 8'h00;
    field_ok   = 1'b0;
    for (int unsigned f = 0; f < FIELDS; f++) begin
      if (32'(rom_byte[6:1]) == f) begin
        field_byte = fields_q[8*f +: 8];
        field_ok   = 1'b1;
      end
    end
    nibble = rom_byte[0] ? field_byte[3:0] : field_byte[7:4];
    if (!rom_byte[7]) begin
      sub_byte = rom_byte;
    end else if (!field_ok) begin
      sub_byte = 8'h3F;
    end else if (nibble <= 4'd9) begin
      sub_byte = 8'h30 + {4'h0, nibble};
    end else begin
      sub_byte = 8'h37 + {4'h0, nibble};  // 'A' + (n - 10)
    end
  end

  assign msg_in_range = (32'(msgSel) < NUM_MSGS);

  // Next-state logic: start acceptance, fetch/send handshake and the done pulse.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    msg_d       = msg_q;
    fields_d    = fields_q;
    error_d     = error_q;
    char_data_d = char_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          msg_d    = msgSel;
          fields_d = fields;
          idx_d    = '0;
          if (msg_in_range) begin
            state_d = StFetch;
          end else begin
            state_d = StDone;
            error_d = 1'b1;
          end
        end
      end
      StFetch: begin
        // The substituted ROM byte is registered straight into the output holding register.
        char_data_d = sub_byte;
        state_d     = StSend;
      end
      StSend: begin
        if (charReady) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        error_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      msg_q       <= '0;
      fields_q    <= '0;
      error_q     <= 1'b0;
      char_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      msg_q       <= msg_d;
      fields_q    <= fields_d;
      error_q     <= error_d;
      char_data_q <= char_data_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign error     = error_q;
  assign charValid = (state_q == StSend);
  assign charData  = char_data_q;
  assign charIdx   = idx_q;

endmodule

// File: tb/tb_lcd_msg_streamer.sv
// Bench for lcd_msg_streamer: directed sequence with random fields and random charReady,
// checked against a screen-level model of the expected character stream.
module tb_lcd_msg_streamer;

  localparam int unsigned NUM_MSGS   = 3;
  localparam int unsigned LINE_CHARS = 16;
  localparam int unsigned FIELDS     = 3;
  localparam int unsigned SCR        = 2 * LINE_CHARS;
  localparam int unsigned IMG_BYTES  = NUM_MSGS * SCR;

  // Test image: mixed plain ASCII and slot bytes; screen 0 starts with directed slots.
  function automatic logic [IMG_BYTES*8-1:0] build_image();
    logic [IMG_BYTES*8-1:0] img;
    img = '0;
    for (int m = 0; m < int'(NUM_MSGS); m++) begin
      for (int i = 0; i < int'(SCR); i++) begin
        logic [7:0] b;
        if (i % 5 == 3) b = 8'h80 | 8'(((i / 5) % 4) << 1) | 8'(i & 1);
        else            b = 8'(33 + (i * 3 + m * 11) % 90);
        img[8*(m*int'(SCR)+i) +: 8] = b;
      end
    end
    img[8*0 +: 8] = 8'h48;  // 'H'
    img[8*1 +: 8] = 8'h80;  // field 0 high
    img[8*2 +: 8] = 8'h81;  // field 0 low
    img[8*3 +: 8] = 8'h82;  // field 1 high
    img[8*4 +: 8] = 8'h83;  // field 1 low
    img[8*5 +: 8] = 8'h84;  // field 2 high
    img[8*6 +: 8] = 8'h85;  // field 2 low
    img[8*7 +: 8] = 8'h86;  // field 3: absent
    img[8*8 +: 8] = 8'hFF;  // field 63: absent
    return img;
  endfunction

  localparam logic [IMG_BYTES*8-1:0] IMG = build_image();

  // Expected character of screen m, position i, given the fields captured at start.
  function automatic logic [7:0] exp_char(input int m, input int i,
                                          input logic [FIELDS*8-1:0] f);
    string hex_digits;
    logic [7:0] b;
    logic [7:0] fv;
    int fi;
    int n;
    hex_digits = "0123456789ABCDEF";
    b = IMG[8*(m*int'(SCR)+i) +: 8];
    if (b[7] == 1'b0) return b;
    fi = int'(b[6:1]);
    if (fi >= int'(FIELDS)) return 8'h3F;
    fv = f[8*fi +: 8];
    n = b[0] ? int'(fv[3:0]) : int'(fv[7:4]);
    return hex_digits[n];
  endfunction

  logic                 clock;
  logic                 resetN;
  logic                 start;
  logic [1:0]           msgSel;
  logic [FIELDS*8-1:0]  fields;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 charValid;
  logic                 charReady;
  logic [7:0]           charData;
  logic [4:0]           charIdx;

  int total;
  int bad;
  logic [7:0] got [SCR];

  lcd_msg_streamer #(
    .NUM_MSGS  (NUM_MSGS),
    .LINE_CHARS(LINE_CHARS),
    .FIELDS    (FIELDS),
    .MSG_IMAGE (IMG)
  ) dut (
    .clock    (clock),
    .resetN   (resetN),
    .start    (start),
    .msgSel   (msgSel),
    .fields   (fields),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .charValid(charValid),
    .charReady(charReady),
    .charData (charData),
    .charIdx  (charIdx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_screen(input int m, input logic [FIELDS*8-1:0] f);
    start  = 1'b1;
    msgSel = 2'(m);
    fields = f;
    tick();
    start  = 1'b0;
  endtask

  // Called in cycle k+1; returns in the done cycle. c counts cycles after the start edge.
  task automatic run_screen(input int m, input logic [FIELDS*8-1:0] snap, input int duty,
                            input bit timed, input bit poke);
    int c;
    int next_idx;
    bit fin;
    c = 1;
    next_idx = 0;
    fin = 1'b0;
    while (!fin && c < 3000) begin
      if (charValid) begin
        if (timed && next_idx == 0) check("first_valid_cycle", 32'(c), 32'd2);
        check("char_idx", 32'(charIdx), 32'(next_idx));
        check("char_data", 32'(charData), 32'(exp_char(m, next_idx % int'(SCR), snap)));
        got[next_idx % int'(SCR)] = charData;
      end
      if (done) begin
        check("done_error", 32'(error), 32'd0);
        check("accept_count", 32'(next_idx), 32'(SCR));
        if (timed) check("done_cycle", 32'(c), 32'(2 * SCR + 1));
        fin = 1'b1;
        charReady = 1'b0;
      end else begin
        check("busy_run", 32'(busy), 32'd1);
        charReady = (int'($urandom_range(99)) < duty);
        if (charValid && charReady) next_idx++;
        if (poke) begin
          start = (c == 9);
          if (c == 9) begin
            fields = ~snap;
            msgSel = 2'((m + 1) % int'(NUM_MSGS));
          end
        end
        tick();
        c++;
      end
    end
    start = 1'b0;
    if (!fin) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [FIELDS*8-1:0] f;
    bit hit;
    total = 0;
    bad = 0;
    resetN = 1'b0;
    start = 1'b0;
    msgSel = '0;
    fields = '0;
    charReady = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(charValid), 32'd0);
    check("rst_idx", 32'(charIdx), 32'd0);
    check("rst_data", 32'(charData), 32'd0);
    resetN = 1'b1;
    tick();

    // Full screen 0 with ready high: exact timing and directed slot values
    charReady = 1'b1;
    f = 24'h5AE13C;
    start_screen(0, f);
    check("busy_k1", 32'(busy), 32'd1);
    check("valid_k1", 32'(charValid), 32'd0);
    run_screen(0, f, 100, 1'b1, 1'b0);
    check("slot_3", 32'(got[1]), 32'h33);
    check("slot_C", 32'(got[2]), 32'h43);
    check("slot_E", 32'(got[3]), 32'h45);
    check("slot_A", 32'(got[6]), 32'h41);
    check("slot_f3", 32'(got[7]), 32'h3F);
    check("slot_f63", 32'(got[8]), 32'h3F);
    tick();
    check("idle_after_done", 32'(busy), 32'd0);

    // Random backpressure on every screen
    for (int r = 0; r < int'(NUM_MSGS); r++) begin
      f = 24'($urandom);
      start_screen(r, f);
      run_screen(r, f, 30, 1'b0, 1'b0);
      tick();
    end

    // Fields change and a second start mid-screen
    f = 24'($urandom);
    start_screen(1, f);
    run_screen(1, f, 60, 1'b0, 1'b1);
    tick();
    check("mid_start_busy", 32'(busy), 32'd0);
    check("mid_start_done", 32'(done), 32'd0);
    tick();
    check("mid_start_busy2", 32'(busy), 32'd0);

    // Out-of-range screen
    start_screen(3, 24'h123456);
    check("bad_done", 32'(done), 32'd1);
    check("bad_error", 32'(error), 32'd1);
    check("bad_busy", 32'(busy), 32'd1);
    check("bad_valid", 32'(charValid), 32'd0);
    tick();
    check("bad_done2", 32'(done), 32'd0);
    check("bad_error2", 32'(error), 32'd0);
    check("bad_busy2", 32'(busy), 32'd0);
    check("bad_valid2", 32'(charValid), 32'd0);

    // Reset during a stall at idx 5
    f = 24'($urandom);
    start_screen(2, f);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (charValid && charIdx == 5'd5) begin
        charReady = 1'b0;
        hit = 1'b1;
      end else begin
        charReady = 1'b1;
        tick();
      end
    end
    check("reach_idx5", 32'(hit), 32'd1);
    tick();
    tick();
    check("stall_valid", 32'(charValid), 32'd1);
    check("stall_idx", 32'(charIdx), 32'd5);
    check("stall_data", 32'(charData), 32'(exp_char(2, 5, f)));
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_valid", 32'(charValid), 32'd0);
    check("mid_rst_data", 32'(charData), 32'd0);
    check("mid_rst_idx", 32'(charIdx), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    f = 24'($urandom);
    start_screen(2, f);
    run_screen(2, f, 50, 1'b0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
